serial_frame_tx: RTL and testbench

- Parallel-to-serial frame transmitter. Drives the 1-bit serial line `x` consumed by the serial-to-serial converter / frame receiver blocks in this design.
- Accepts data words over a valid/ready handshake and buffers one word while another is shifting out.
- Serialises each word as: start marker, data LSB-first, then a fixed inter-frame gap.
- Used by benches and by the front end that feeds the converter.

---
 rtl/serial_frame_tx.sv | 243 ++++++++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Parallel-to-serial frame transmitter. Each accepted word is sent on the
// one-bit line `x` as:
//   start marker (1) | DATA_W data bits, LSB first | [parity] | GAP_BITS zeros
// The line idles low. Every bit lasts BIT_DIV clock cycles.
//
// One holding register buffers the next word while the current one shifts
// out. When a word is waiting at the end of a gap, the next frame starts on
// the following bit, so back-to-back frames have no idle bit between them.
//
// Optional feature (compile-time macro):
//   SERIAL_FRAME_TX_PARITY_EN - when defined, an even-parity bit (XOR of the
//                               data bits) is sent after the data bits.
//
// Parameters:
//   DATA_W    data bits per frame
//   BIT_DIV   clock cycles per serial bit (>= 1)
//   GAP_BITS  idle-low bit times after each frame (>= 1)
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset, released synchronously
//   in_data     word to send
//   in_valid    in_data valid
//   in_ready    holding register empty; a word is taken when in_valid & in_ready
//   x           serial line, registered, idle low
//   busy        frame in progress (start marker through gap)
//   frame_done  one-cycle pulse on the last clock of the gap
//   sent_cnt    completed frames, wraps 16'hFFFF -> 0
//
// Output timing: x, busy, frame_done and sent_cnt are all registered from the
// current FSM state, so they trail the state register by one clock and stay
// aligned with each other. A word accepted at edge N shows its start marker
// on x from edge N+2.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int DATA_W   = 8,
  parameter int BIT_DIV  = 1,
  parameter int GAP_BITS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       sent_cnt
);

  // Bit-timer width; keep at least one bit even when BIT_DIV == 1.
  localparam int TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  // Bit index counter covers both the data bits and the gap bits.
  localparam int CW = $clog2(DATA_W + GAP_BITS + 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int SW = 3;
  localparam logic [SW-1:0] S_IDLE   = 3'd0;
  localparam logic [SW-1:0] S_START  = 3'd1;
  localparam logic [SW-1:0] S_DATA   = 3'd2;
  localparam logic [SW-1:0] S_GAP    = 3'd3;
  localparam logic [SW-1:0] S_PARITY = 3'd4;
`else
  localparam int SW = 2;
  localparam logic [SW-1:0] S_IDLE   = 2'd0;
  localparam logic [SW-1:0] S_START  = 2'd1;
  localparam logic [SW-1:0] S_DATA   = 2'd2;
  localparam logic [SW-1:0] S_GAP    = 2'd3;
`endif

  logic [SW-1:0]     state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              x_q, x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       cnt_q, cnt_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic tick;    // last clock of the current bit time
  logic accept;  // handshake completes at the next edge
  logic load;    // hold -> sh transfer at the next edge

  assign tick   = (timer_q == TW'(BIT_DIV - 1));
  assign accept = in_valid & ~hold_full_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    hold_d  = hold_q;
    x_d     = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // The bit timer only runs inside a frame so that every frame starts
    // with a full-length start bit.
    if (state_q != S_IDLE) begin
      timer_d = tick ? '0 : timer_q + 1'b1;
    end else begin
      timer_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        x_d = 1'b0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        x_d = 1'b1;
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end

      S_DATA: begin
        x_d = sh_q[0];
        if (tick) begin
          sh_d = sh_q >> 1;
          if (bit_q == CW'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_GAP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        x_d = parity_q;
        if (tick) begin
          state_d = S_GAP;
          bit_d   = '0;
        end
      end
`endif

      S_GAP: begin
        x_d = 1'b0;
        if (tick) begin
          if (bit_q == CW'(GAP_BITS - 1)) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
            bit_d  = '0;
            // A waiting word starts immediately: no idle bit between frames.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      sh_d = hold_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      // Parity is taken from the whole word now, since sh is consumed bit
      // by bit while the frame is sent.
      parity_d = ^hold_q;
`endif
    end

    // accept only happens with hold empty and load only with hold full,
    // so a same-cycle accept and load never clash over the register.
    if (accept) begin
      hold_d = in_data;
    end
    hold_full_d = (hold_full_q & ~load) | accept;

    busy_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      x_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign in_ready   = ~hold_full_q;
  assign x          = x_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign sent_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Bench for serial_frame_tx. Two instances share clock and reset:
//   index 0: BIT_DIV = 1,  index 1: BIT_DIV = 3  (DATA_W = 8, GAP_BITS = 2)
// Every cycle the outputs of both are logged on the falling edge; each test
// compares the log against frames built from the word list by a simple
// bit-list model (start, data LSB first, optional parity, gap zeros, each bit
// repeated BIT_DIV times).
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

  localparam int DW  = 8;
  localparam int GAP = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FBITS = 1 + DW + PB + GAP;

  typedef struct packed {
    logic x;
    logic fd;
    logic busy;
    logic rdy;
  } smp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] din [2];
  logic          vld [2];
  logic          rdy [2];
  logic          xs  [2];
  logic          bsy [2];
  logic          fd  [2];
  logic [15:0]   cnt [2];

  int checks = 0;
  int failures = 0;

  smp_t q0[$];
  smp_t q1[$];

  logic [DW-1:0] wbuf [8];
  int            acc_idx [8];
  logic [15:0]   exp_cnt [2];

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(DW), .BIT_DIV(1), .GAP_BITS(GAP)) dut1 (
    .clock(clk), .reset_n(reset_n), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .x(xs[0]), .busy(bsy[0]), .frame_done(fd[0]),
    .sent_cnt(cnt[0])
  );

  serial_frame_tx #(.DATA_W(DW), .BIT_DIV(3), .GAP_BITS(GAP)) dut3 (
    .clock(clk), .reset_n(reset_n), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .x(xs[1]), .busy(bsy[1]), .frame_done(fd[1]),
    .sent_cnt(cnt[1])
  );

  always @(negedge clk) begin
    q0.push_back({xs[0], fd[0], bsy[0], rdy[0]});
    q1.push_back({xs[1], fd[1], bsy[1], rdy[1]});
  end

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  function automatic smp_t samp(input int sel, input int idx);
    if (sel == 0) return q0[idx];
    return q1[idx];
  endfunction

  function automatic int dv(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  // Offer wbuf[0..n-1] one after the other, keeping in_valid high between
  // words. acc_idx[w] is the log index of the sample right after the
  // accepting edge.
  task automatic send_words(input int sel, input int n);
    for (int w = 0; w < n; w++) begin
      bit got;
      got = 1'b0;
      @(negedge clk); #1;
      din[sel] = wbuf[w];
      vld[sel] = 1'b1;
      for (int t = 0; t < 200 && !got; t++) begin
        if (rdy[sel]) begin
          acc_idx[w] = qsize(sel);
          got = 1'b1;
          @(posedge clk);
        end else begin
          @(negedge clk); #1;
        end
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL accept_timeout dut=%0d word=%0d got=no-handshake required=handshake", sel, w);
        acc_idx[w] = qsize(sel);
      end else begin
        $display("TX dut=%0d word=%02h accepted at sample %0d", sel, wbuf[w], acc_idx[w]);
      end
    end
    @(negedge clk); #1;
    vld[sel] = 1'b0;
    din[sel] = DW'($urandom);   // must not disturb frames already taken
  endtask

  // Build the expected line from wbuf and compare with the log.
  task automatic check_frames(input int sel, input int n, input string name);
    logic ex[$];
    logic ef[$];
    int   base, len;
    smp_t s;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < FBITS; b++) begin
        logic v;
        if (b == 0) v = 1'b1;
        else if (b <= DW) v = wbuf[w][b-1];
        else if (PB == 1 && b == DW + 1) v = ^wbuf[w];
        else v = 1'b0;
        for (int r = 0; r < dv(sel); r++) begin
          ex.push_back(v);
          ef.push_back((b == FBITS - 1) && (r == dv(sel) - 1));
        end
      end
    end
    len  = ex.size();
    base = acc_idx[0];
    for (int t = 0; t < 5000 && qsize(sel) < base + len + 4; t++) @(negedge clk);
    checks++;
    if (qsize(sel) < base + len + 4) begin
      failures++;
      $display("FAIL %s_wait dut=%0d got=%0d samples required=%0d", name, sel, qsize(sel), base + len + 4);
      return;
    end
    #1;
    s = samp(sel, base + 1);
    checks++;
    if (s.x !== 1'b0 || s.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_latency dut=%0d got x=%b busy=%b required x=0 busy=0", name, sel, s.x, s.busy);
    end
    for (int w = 0; w < n; w++) begin
      s = samp(sel, acc_idx[w]);
      checks++;
      if (s.rdy !== 1'b0) begin
        failures++;
        $display("FAIL %s_ready_hold dut=%0d word=%0d got in_ready=%b required 0", name, sel, w, s.rdy);
      end
    end
    for (int i = 0; i < len; i++) begin
      s = samp(sel, base + 2 + i);
      checks++;
      if (s.x !== ex[i] || s.fd !== ef[i] || s.busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_line dut=%0d cycle=%0d got x=%b fd=%b busy=%b required x=%b fd=%b busy=1",
                 name, sel, i, s.x, s.fd, s.busy, ex[i], ef[i]);
      end
    end
    s = samp(sel, base + 2 + len);
    checks++;
    if (s.x !== 1'b0 || s.busy !== 1'b0 || s.fd !== 1'b0) begin
      failures++;
      $display("FAIL %s_after dut=%0d got x=%b busy=%b fd=%b required x=0 busy=0 fd=0", name, sel, s.x, s.busy, s.fd);
    end
    exp_cnt[sel] = exp_cnt[sel] + 16'(n);
    checks++;
    if (cnt[sel] !== exp_cnt[sel]) begin
      failures++;
      $display("FAIL %s_sent_cnt dut=%0d got=%0d required=%0d", name, sel, cnt[sel], exp_cnt[sel]);
    end
    $display("CHK %s dut=%0d frames=%0d cycles=%0d sent_cnt=%0d", name, sel, n, len, cnt[sel]);
  endtask

  task automatic check_idle_outputs(input string name);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (xs[s] !== 1'b0 || rdy[s] !== 1'b1 || bsy[s] !== 1'b0 || fd[s] !== 1'b0 || cnt[s] !== 16'd0) begin
        failures++;
        $display("FAIL %s dut=%0d got x=%b rdy=%b busy=%b fd=%b cnt=%0d required x=0 rdy=1 busy=0 fd=0 cnt=0",
                 name, s, xs[s], rdy[s], bsy[s], fd[s], cnt[s]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("post_reset");
  endtask

  task automatic test_single();
    wbuf[0] = 8'hA5;
    send_words(0, 1);
    check_frames(0, 1, "single");
  endtask

  task automatic test_back_to_back();
    wbuf[0] = 8'h01;
    wbuf[1] = 8'h80;
    send_words(0, 2);
    // the second word must be waiting before the first frame ends
    checks++;
    if (acc_idx[1] >= acc_idx[0] + 2 + FBITS - 1) begin
      failures++;
      $display("FAIL b2b_second_accept got=%0d required<%0d", acc_idx[1], acc_idx[0] + 2 + FBITS - 1);
    end
    check_frames(0, 2, "b2b");
  endtask

  task automatic test_divider();
    wbuf[0] = 8'hFF;
    send_words(1, 1);
    check_frames(1, 1, "divider");
  endtask

  task automatic test_parity();
    wbuf[0] = 8'h07;
    wbuf[1] = 8'h03;
    send_words(0, 2);
    check_frames(0, 2, "parity");
`ifdef SERIAL_FRAME_TX_PARITY_EN
    begin
      smp_t s;
      s = samp(0, acc_idx[0] + 2 + 1 + DW);
      checks++;
      if (s.x !== 1'b1) begin
        failures++;
        $display("FAIL parity_07 got=%b required=1", s.x);
      end
      s = samp(0, acc_idx[0] + 2 + 12 + 1 + DW);
      checks++;
      if (s.x !== 1'b0) begin
        failures++;
        $display("FAIL parity_03 got=%b required=0", s.x);
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int sel, n;
      sel = r % 2;
      n   = $urandom_range(1, 3);
      for (int w = 0; w < n; w++) wbuf[w] = DW'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_words(sel, n);
      check_frames(sel, n, "random");
    end
  endtask

  task automatic test_reset_mid();
    int a;
    smp_t s;
    wbuf[0] = 8'hA5;
    wbuf[1] = DW'($urandom);
    send_words(0, 2);
    a = acc_idx[0];
    for (int t = 0; t < 100 && qsize(0) <= a + 6; t++) @(negedge clk);
    #1;
    s = samp(0, a + 6);   // DATA bit 3 of 8'hA5 is on the line
    checks++;
    if (s.busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_inframe got busy=%b required 1", s.busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (xs[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || cnt[0] !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid_async got x=%b busy=%b rdy=%b cnt=%0d required x=0 busy=0 rdy=1 cnt=0",
               xs[0], bsy[0], rdy[0], cnt[0]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    a = qsize(0);
    repeat (30) @(negedge clk);
    #1;
    for (int i = a; i < a + 30; i++) begin
      s = samp(0, i);
      checks++;
      if (s.x !== 1'b0 || s.busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_quiet sample=%0d got x=%b busy=%b required x=0 busy=0", i - a, s.x, s.busy);
      end
    end
    $display("CHK rst_mid line quiet after release");
  endtask

  task automatic test_wrap();
    @(negedge clk); #1;
    force dut1.cnt_q = 16'hFFFF;
    @(negedge clk); #1;
    release dut1.cnt_q;
    exp_cnt[0] = 16'hFFFF;
    wbuf[0] = DW'($urandom);
    send_words(0, 1);
    check_frames(0, 1, "wrap");
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      din[s] = '0;
      vld[s] = 1'b0;
      exp_cnt[s] = 16'd0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_divider();
    test_parity();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
